// File: rtl/lampfpu_sqrt_sched.sv
// lampfpu_sqrt_sched -- two-requester round-robin scheduler in front of a
// single bfloat16 sqrt / inverse-sqrt unit. One operation is in flight at a
// time: IDLE accepts, ISSUE pulses the start strobe, WAIT holds for the
// unit's completion, RESP holds the result until the granted requester takes it.
//
// Optional feature: define LAMP_SQRT_SCHED_TIMEOUT_EN to build an 8-bit
// watchdog that aborts a WAIT lasting TIMEOUT_CYC cycles with a QNaN result
// and rsp_err_o = 1. Without it, WAIT lasts until the unit answers and
// rsp_err_o is tied low.
module lampfpu_sqrt_sched #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [1:0][15:0] req_op_a_i,
  output logic             do_sqrt_o,
  output logic             do_inv_sqrt_o,
  output logic [15:0]      op_a_o,
  input  logic             unit_valid_i,
  input  logic [20:0]      unit_res_i,
  input  logic [2:0]       unit_flags_i,
  output logic [1:0]       rsp_valid_o,
  input  logic [1:0]       rsp_ready_i,
  output logic [20:0]      rsp_res_o,
  output logic [2:0]       rsp_flags_o,
  output logic             rsp_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;       // requester favoured on a tie
  logic        gnt_q, gnt_d;       // requester owning the in-flight op
  logic        op_q, op_d;         // 0 = sqrt, 1 = inverse sqrt
  logic [15:0] op_a_q, op_a_d;
  logic [20:0] res_q, res_d;
  logic [2:0]  flags_q, flags_d;

  logic        any_req;
  logic        grant_id;

`ifdef LAMP_SQRT_SCHED_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
  localparam logic [20:0] TIMEOUT_RES = 21'h0FF40;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  // Round-robin choice: the pointer's requester if it asks, else the other one.
  always_comb begin
    any_req  = |req_valid_i;
    grant_id = req_valid_i[ptr_q] ? ptr_q : ~ptr_q;
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      op_q    <= 1'b0;
      op_a_q  <= '0;
      res_q   <= '0;
      flags_q <= '0;
`ifdef LAMP_SQRT_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      op_a_q  <= op_a_d;
      res_q   <= res_d;
      flags_q <= flags_d;
`ifdef LAMP_SQRT_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and capture logic for accept, issue, wait and response.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    op_a_d  = op_a_q;
    res_d   = res_q;
    flags_d = flags_q;
`ifdef LAMP_SQRT_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = grant_id;
          op_d    = req_op_i[grant_id];
          op_a_d  = req_op_a_i[grant_id];
          ptr_d   = ~grant_id;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef LAMP_SQRT_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (unit_valid_i) begin
          res_d   = unit_res_i;
          flags_d = unit_flags_i;
`ifdef LAMP_SQRT_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef LAMP_SQRT_SCHED_TIMEOUT_EN
        else if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
          res_d   = TIMEOUT_RES;
          flags_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready_i[gnt_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and strobe outputs decoded from the current state.
  always_comb begin
    req_ready_o   = '0;
    rsp_valid_o   = '0;
    do_sqrt_o     = 1'b0;
    do_inv_sqrt_o = 1'b0;
    if (state_q == S_IDLE && any_req && !rst) begin
      req_ready_o[grant_id] = 1'b1;
    end
    if (state_q == S_ISSUE) begin
      do_sqrt_o     = ~op_q;
      do_inv_sqrt_o = op_q;
    end
    if (state_q == S_RESP) begin
      rsp_valid_o[gnt_q] = 1'b1;
    end
  end

  assign op_a_o      = op_a_q;
  assign rsp_res_o   = res_q;
  assign rsp_flags_o = flags_q;
`ifdef LAMP_SQRT_SCHED_TIMEOUT_EN
  assign rsp_err_o   = err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_lampfpu_sqrt_sched.sv
// Directed bench for lampfpu_sqrt_sched: single op, round-robin contention,
// response back-pressure, reset mid-WAIT and watchdog behaviour.
module tb_lampfpu_sqrt_sched;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0]       req_op_i;
  logic [1:0][15:0] req_op_a_i;
  logic             do_sqrt_o;
  logic             do_inv_sqrt_o;
  logic [15:0]      op_a_o;
  logic             unit_valid_i;
  logic [20:0]      unit_res_i;
  logic [2:0]       unit_flags_i;
  logic [1:0]       rsp_valid_o;
  logic [1:0]       rsp_ready_i;
  logic [20:0]      rsp_res_o;
  logic [2:0]       rsp_flags_o;
  logic             rsp_err_o;

  int tests = 0;
  int fails = 0;

  lampfpu_sqrt_sched #(.TIMEOUT_CYC(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_op_a_i    (req_op_a_i),
    .do_sqrt_o     (do_sqrt_o),
    .do_inv_sqrt_o (do_inv_sqrt_o),
    .op_a_o        (op_a_o),
    .unit_valid_i  (unit_valid_i),
    .unit_res_i    (unit_res_i),
    .unit_flags_i  (unit_flags_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_res_o     (rsp_res_o),
    .rsp_flags_o   (rsp_flags_o),
    .rsp_err_o     (rsp_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_ready"}, 32'(req_ready_o), 32'h0);
    check({tag, ".do_sqrt"},   32'(do_sqrt_o), 32'h0);
    check({tag, ".do_inv"},    32'(do_inv_sqrt_o), 32'h0);
    check({tag, ".op_a"},      32'(op_a_o), 32'h0);
    check({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'h0);
    check({tag, ".rsp_res"},   32'(rsp_res_o), 32'h0);
    check({tag, ".rsp_flags"}, 32'(rsp_flags_o), 32'h0);
    check({tag, ".rsp_err"},   32'(rsp_err_o), 32'h0);
  endtask

  logic [20:0] exp_res;
  int          g;

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    req_valid_i = 2'b11;
    req_op_i = 2'b00;
    req_op_a_i[0] = 16'h0000;
    req_op_a_i[1] = 16'h0000;
    unit_valid_i = 1'b0;
    unit_res_i = '0;
    unit_flags_i = '0;
    rsp_ready_i = 2'b00;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    check_all_zero("reset_held");
    $display("[TB] reset state checked");

    // ---------------- single sqrt of 4.0 ----------------
    rst = 1'b0;
    req_valid_i = 2'b01;
    req_op_i = 2'b00;
    req_op_a_i[0] = 16'h4080;
    #1;
    check("single.req_ready", 32'(req_ready_o), 32'h1);
    tick();
    req_valid_i = 2'b00;
    #1;
    check("single.do_sqrt", 32'(do_sqrt_o), 32'h1);
    check("single.do_inv", 32'(do_inv_sqrt_o), 32'h0);
    check("single.op_a", 32'(op_a_o), 32'h4080);
    check("single.ready_issue", 32'(req_ready_o), 32'h0);
    tick();
    check("single.pulse_once", 32'({do_sqrt_o, do_inv_sqrt_o}), 32'h0);
    check("single.op_a_hold", 32'(op_a_o), 32'h4080);
    unit_valid_i = 1'b1;
    unit_res_i = 21'h080000;   // +2.0: sign 0, exp 0x80, frac 0
    unit_flags_i = 3'b001;
    tick();
    unit_valid_i = 1'b0;
    check("single.rsp_valid", 32'(rsp_valid_o), 32'h1);
    check("single.rsp_res", 32'(rsp_res_o), 32'h080000);
    check("single.rsp_flags", 32'(rsp_flags_o), 32'h1);
    check("single.rsp_err", 32'(rsp_err_o), 32'h0);
    rsp_ready_i = 2'b10;       // wrong index: must be ignored
    tick();
    check("single.wrong_ready", 32'(rsp_valid_o), 32'h1);
    rsp_ready_i = 2'b01;
    tick();
    rsp_ready_i = 2'b00;
    check("single.done", 32'(rsp_valid_o), 32'h0);
    $display("[TB] single sqrt 0x4080 -> res %h", exp_res);

    // ---------------- contention from reset ----------------
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req_valid_i = 2'b11;
    req_op_i = 2'b10;
    req_op_a_i[0] = 16'h3F80;
    req_op_a_i[1] = 16'h4100;
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      exp_res = 21'h001000 + 21'(i);
      #1;
      check("rr.req_ready", 32'(req_ready_o), 32'(2'b01 << g));
      tick();
      check("rr.do_sqrt", 32'(do_sqrt_o), 32'(g == 0));
      check("rr.do_inv", 32'(do_inv_sqrt_o), 32'(g == 1));
      check("rr.op_a", 32'(op_a_o), (g == 0) ? 32'h3F80 : 32'h4100);
      check("rr.no_accept_issue", 32'(req_ready_o), 32'h0);
      tick();
      check("rr.no_overlap", 32'({do_sqrt_o, do_inv_sqrt_o}), 32'h0);
      check("rr.no_accept_wait", 32'(req_ready_o), 32'h0);
      unit_valid_i = 1'b1;
      unit_res_i = exp_res;
      unit_flags_i = 3'b100;
      tick();
      unit_valid_i = 1'b0;
      check("rr.rsp_valid", 32'(rsp_valid_o), 32'(2'b01 << g));
      check("rr.rsp_res", 32'(rsp_res_o), 32'(exp_res));
      check("rr.no_accept_resp", 32'(req_ready_o), 32'h0);
      rsp_ready_i = 2'(2'b01 << g);
      tick();
      rsp_ready_i = 2'b00;
      $display("[TB] contention op %0d granted requester %0d res %h", i, g, rsp_res_o);
    end

    // ---------------- inverse sqrt on req1 with back-pressure ----------------
    req_valid_i = 2'b10;
    req_op_i = 2'b10;
    req_op_a_i[1] = 16'h4080;
    #1;
    check("bp.req_ready", 32'(req_ready_o), 32'h2);
    tick();
    check("bp.do_inv", 32'(do_inv_sqrt_o), 32'h1);
    check("bp.do_sqrt", 32'(do_sqrt_o), 32'h0);
    tick();
    req_valid_i = 2'b11;
    unit_valid_i = 1'b1;
    unit_res_i = 21'h07E000;   // +0.5: sign 0, exp 0x7E, frac 0
    unit_flags_i = 3'b010;
    tick();
    unit_valid_i = 1'b0;
    unit_res_i = 21'h1FFFFF;   // garbage on the bus must not leak through
    rsp_ready_i = 2'b01;       // wrong index held for ten cycles
    for (int i = 0; i < 10; i++) begin
      check("bp.rsp_valid", 32'(rsp_valid_o), 32'h2);
      check("bp.rsp_res", 32'(rsp_res_o), 32'h07E000);
      check("bp.rsp_flags", 32'(rsp_flags_o), 32'h2);
      check("bp.no_accept", 32'(req_ready_o), 32'h0);
      tick();
    end
    rsp_ready_i = 2'b10;
    tick();
    rsp_ready_i = 2'b00;
    check("bp.done", 32'(rsp_valid_o), 32'h0);
    check("bp.next_grant", 32'(req_ready_o), 32'h1);
    req_valid_i = 2'b00;
    #1;
    check("bp.ready_follows_valid", 32'(req_ready_o), 32'h0);
    $display("[TB] inverse sqrt req1 held 10 cycles, res %h", rsp_res_o);

    // ---------------- reset in the third WAIT cycle ----------------
    req_valid_i = 2'b01;
    req_op_i = 2'b00;
    req_op_a_i[0] = 16'h4080;
    tick();
    req_valid_i = 2'b00;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("midwait_rst");
    rst = 1'b0;
    unit_valid_i = 1'b1;
    unit_res_i = 21'h080000;
    tick();
    unit_valid_i = 1'b0;
    check("midwait.late_valid", 32'(rsp_valid_o), 32'h0);
    check("midwait.no_pulse", 32'({do_sqrt_o, do_inv_sqrt_o}), 32'h0);
    tick();
    check("midwait.still_idle", 32'(rsp_valid_o), 32'h0);
    $display("[TB] reset mid-WAIT dropped the operation");

    // ---------------- unit never answers ----------------
    req_valid_i = 2'b01;
    tick();
    req_valid_i = 2'b00;
    tick();                    // now in the first WAIT cycle
    for (int i = 0; i < 7; i++) tick();
    check("to.before_limit", 32'(rsp_valid_o), 32'h0);
    tick();
`ifdef LAMP_SQRT_SCHED_TIMEOUT_EN
    check("to.rsp_valid", 32'(rsp_valid_o), 32'h1);
    check("to.rsp_err", 32'(rsp_err_o), 32'h1);
    check("to.rsp_res", 32'(rsp_res_o), 32'h0FF40);
    check("to.rsp_flags", 32'(rsp_flags_o), 32'h0);
    rsp_ready_i = 2'b01;
    tick();
    rsp_ready_i = 2'b00;
    req_valid_i = 2'b10;
    req_op_i = 2'b00;
    req_op_a_i[1] = 16'h3F80;
    tick();
    req_valid_i = 2'b00;
    tick();
    unit_valid_i = 1'b1;
    unit_res_i = 21'h07F000;
    unit_flags_i = 3'b000;
    tick();
    unit_valid_i = 1'b0;
    check("to.err_cleared", 32'(rsp_err_o), 32'h0);
    check("to.next_res", 32'(rsp_res_o), 32'h07F000);
    rsp_ready_i = 2'b10;
    tick();
    rsp_ready_i = 2'b00;
    $display("[TB] watchdog aborted op with QNaN, next op clean");
`else
    check("to.no_rsp", 32'(rsp_valid_o), 32'h0);
    check("to.no_err", 32'(rsp_err_o), 32'h0);
    for (int i = 0; i < 20; i++) tick();
    check("to.no_rsp_late", 32'(rsp_valid_o), 32'h0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    $display("[TB] no watchdog: WAIT held with no response");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lampfpu_sqrt_sched.md
LAMPFPU_SQRT_SCHED -- requirements
Module: lampfpu_sqrt_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: watchdog limit in cycles; legal range 2..255.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid_i  in  2  per-requester request valid (index 0, 1).
REQ-005 req_ready_o  out  2  per-requester request accepted this cycle.
REQ-006 req_op_i  in  2  per-requester op: 0 = sqrt, 1 = inverse sqrt.
REQ-007 req_op_a_i  in  2x16  per-requester bfloat16 operand.
REQ-008 do_sqrt_o, do_inv_sqrt_o  out  1 each  one-cycle start pulses to the sqrt unit.
REQ-009 op_a_o  out  16  operand to the unpack/sqrt path, held stable from the start pulse until completion.
REQ-010 unit_valid_i  in  1  sqrt unit completion strobe.
REQ-011 unit_res_i  in  21  {sign, exp[7:0], frac+guard[11:0]} from the sqrt unit.
REQ-012 unit_flags_i  in  3  {isOverflow, isUnderflow, isToRound}.
REQ-013 rsp_valid_o  out  2  per-requester response valid.
REQ-014 rsp_ready_i  in  2  per-requester response ready.
REQ-015 rsp_res_o  out  21;  rsp_flags_o  out  3;  rsp_err_o  out  1  (timeout abort), shared by both requesters.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: when any req_valid_i is set, grant exactly one requester per round-robin pointer, assert its req_ready_o combinationally that cycle, latch op/operand/grant id, go to ISSUE.
REQ-018 Round robin: the pointer moves to the requester not granted on each grant; on a tie the pointer's requester wins; after reset the pointer = 0.
REQ-019 ISSUE: assert exactly one of do_sqrt_o/do_inv_sqrt_o for one cycle, per the latched op, then go to WAIT; start pulse occurs 1 cycle after acceptance.
REQ-020 WAIT: on unit_valid_i, capture res/flags, clear rsp_err_o, go to RESP; unit_valid_i outside WAIT SHALL be ignored.
REQ-021 RESP: assert rsp_valid_o only on the granted index; hold all rsp_* stable until rsp_ready_i on that index, then go to IDLE.
REQ-022 Next request may be accepted in the cycle after the response handshake (IDLE); no accept in ISSUE, WAIT or RESP (req_ready_o = 0).
REQ-023 At most one operation outstanding in the sqrt unit at all times.
REQ-024 req_ready_o SHALL never assert for a requester whose req_valid_i is low.
REQ-025 rsp_ready_i on a non-granted index SHALL have no effect.

Reset
REQ-026 Asserting rst at any time, including mid-WAIT, SHALL force IDLE, RR pointer = 0, all outputs 0 (req_ready_o, do_*, op_a_o, rsp_valid_o, rsp_res_o, rsp_flags_o, rsp_err_o); the in-flight operation is dropped and its later unit_valid_i is ignored per REQ-020.
REQ-027 After rst deasserts, first acceptance may occur in the first clock edge.

Configuration
REQ-028 Macro LAMP_SQRT_SCHED_TIMEOUT_EN: when defined, an 8-bit counter clears on entering WAIT and increments each WAIT cycle; if it reaches TIMEOUT_CYC without unit_valid_i, go to RESP with rsp_res_o = 0x0FF40 (QNaN, sign 0), rsp_flags_o = 0, rsp_err_o = 1.
REQ-029 When the macro is not defined, no counter is built, WAIT lasts indefinitely, and rsp_err_o is tied to 0.

Verification
REQ-030 Single sqrt: req0 op=0 operand 0x4080 (4.0) -> req_ready_o[0] same cycle, do_sqrt_o pulse next cycle, unit returns 2.0 -> rsp_valid_o = 2'b01, rsp_res_o passes 21-bit result unchanged.
REQ-031 Contention: both valid from reset -> grant order 0,1,0,1 over four back-to-back ops; one-hot start pulses; no overlap.
REQ-032 Inverse sqrt on req1 with rsp_ready_i[1] held low 10 cycles -> rsp_* stable 10 cycles, no new accept until handshake.
REQ-033 Reset mid-WAIT (cycle 3 of WAIT) -> all outputs 0 next cycle; late unit_valid_i produces no rsp_valid_o.
REQ-034 With LAMP_SQRT_SCHED_TIMEOUT_EN, TIMEOUT_CYC=8, no unit_valid_i -> rsp_valid_o after 8 WAIT cycles, rsp_err_o=1, rsp_res_o=0x0FF40; without macro -> no response.
